// File: rtl/rc4_sequencer_if.sv
// Client and S-memory bus of the RC4 sequencer.
interface rc4_sequencer_if;
    logic [2:0]  cl_start;
    logic [2:0]  cl_finish;
    logic [2:0]  cl_rd_start;
    logic [2:0]  cl_wr_start;
    logic [23:0] cl_addr;
    logic [23:0] cl_wr_data;
    logic        cl_rd_done;
    logic        cl_wr_done;
    logic [7:0]  cl_rd_data;
    logic [7:0]  ram_addr;
    logic [7:0]  ram_data;
    logic        ram_wren;
    logic [7:0]  ram_q;

    modport master (
        output cl_start, cl_rd_done, cl_wr_done, cl_rd_data,
        output ram_addr, ram_data, ram_wren,
        input  cl_finish, cl_rd_start, cl_wr_start, cl_addr, cl_wr_data,
        input  ram_q
    );

    modport slave (
        input  cl_start, cl_rd_done, cl_wr_done, cl_rd_data,
        input  ram_addr, ram_data, ram_wren,
        output cl_finish, cl_rd_start, cl_wr_start, cl_addr, cl_wr_data,
        output ram_q
    );
endinterface

// File: rtl/rc4_sequencer.sv
// RC4 run sequencer: steps Init -> Key Schedule -> Decrypt clients and
// arbitrates the active client's accesses onto the shared S-memory.
module rc4_sequencer #(
    parameter int unsigned RD_LAT = 2
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            go,
    input  logic            abort,
    rc4_sequencer_if.master bus,
    output logic            busy,
    output logic            done,
    output logic            protocol_err,
    output logic [1:0]      phase
);
    typedef enum logic [2:0] {IDLE, INIT, KSA, PRGA, DONE} phase_t;
    typedef enum logic [1:0] {M_IDLE, M_RD, M_WR} mem_t;

    phase_t     ph, ph_next;
    mem_t       mem, mem_next;
    logic [2:0] cnt;
    logic [7:0] addr_q, data_q, rd_data_q;
    logic [2:0] start_q, start_next;
    logic       wr_done_q, fin_pend, perr_q;
    logic       in_run, rd_req, wr_req, fin_hit, abort_hit;
    logic [1:0] act;
    logic [7:0] req_addr, req_data;
    logic       accept_rd, accept_wr, err_set, advance, rd_fire;

    // Select the active client and qualify its request/finish strobes
    always_comb begin
        in_run = 1'b0;
        act    = 2'd0;
        case (ph)
            INIT:    begin in_run = 1'b1; act = 2'd0; end
            KSA:     begin in_run = 1'b1; act = 2'd1; end
            PRGA:    begin in_run = 1'b1; act = 2'd2; end
            default: ;
        endcase
        req_addr = bus.cl_addr[7:0];
        req_data = bus.cl_wr_data[7:0];
        case (act)
            2'd1:    begin req_addr = bus.cl_addr[15:8];  req_data = bus.cl_wr_data[15:8];  end
            2'd2:    begin req_addr = bus.cl_addr[23:16]; req_data = bus.cl_wr_data[23:16]; end
            default: ;
        endcase
        rd_req    = in_run & bus.cl_rd_start[act];
        wr_req    = in_run & bus.cl_wr_start[act];
        fin_hit   = in_run & bus.cl_finish[act];
        abort_hit = in_run & abort;
        rd_fire   = (mem == M_RD) && (cnt == 3'(RD_LAT));
    end

    // Next-state logic for the phase FSM and the memory engine
    always_comb begin
        ph_next    = ph;
        mem_next   = mem;
        start_next = '0;
        accept_rd  = 1'b0;
        accept_wr  = 1'b0;
        err_set    = 1'b0;
        case (mem)
            M_IDLE: begin
                if (wr_req) begin
                    mem_next  = M_WR;
                    accept_wr = 1'b1;
                    err_set   = rd_req;
                end else if (rd_req) begin
                    mem_next  = M_RD;
                    accept_rd = 1'b1;
                end
            end
            M_RD: begin
                err_set = rd_req | wr_req;
                if (rd_fire) mem_next = M_IDLE;
            end
            M_WR: begin
                err_set  = rd_req | wr_req;
                mem_next = M_IDLE;
            end
            default: mem_next = M_IDLE;
        endcase
        // A finish is held off until the engine is idle and nothing new starts
        advance = (fin_hit | fin_pend) & (mem == M_IDLE) & ~accept_rd & ~accept_wr;
        case (ph)
            IDLE:    if (go) begin ph_next = INIT; start_next = 3'b001; end
            INIT:    if (advance) begin ph_next = KSA; start_next = 3'b010; end
            KSA:     if (advance) begin ph_next = PRGA; start_next = 3'b100; end
            PRGA:    if (advance) ph_next = DONE;
            DONE:    ph_next = IDLE;
            default: ph_next = IDLE;
        endcase
        if (abort_hit) begin
            ph_next    = IDLE;
            mem_next   = M_IDLE;
            start_next = '0;
            accept_rd  = 1'b0;
            accept_wr  = 1'b0;
            err_set    = 1'b0;
            advance    = 1'b0;
        end
    end

    // State registers for both FSMs
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ph  <= IDLE;
            mem <= M_IDLE;
        end else begin
            ph  <= ph_next;
            mem <= mem_next;
        end
    end

    // Request latches, latency counter, pulses and sticky error flag
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            start_q   <= '0;
            wr_done_q <= 1'b0;
            fin_pend  <= 1'b0;
            cnt       <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            rd_data_q <= '0;
            perr_q    <= 1'b0;
        end else begin
            start_q   <= start_next;
            wr_done_q <= (mem == M_WR) && !abort_hit;
            fin_pend  <= (fin_pend | fin_hit) & ~advance & ~abort_hit;
            if (accept_rd)
                cnt <= '0;
            else if (mem == M_RD)
                cnt <= cnt + 3'd1;
            if (accept_rd | accept_wr) addr_q <= req_addr;
            if (accept_wr) data_q <= req_data;
            if (rd_fire) rd_data_q <= bus.ram_q;
            if (ph == IDLE && go)
                perr_q <= 1'b0;
            else if (err_set)
                perr_q <= 1'b1;
        end
    end

    // Status outputs and bus drive; read data bypasses ram_q in the completion cycle
    always_comb begin
        bus.cl_start   = start_q;
        bus.cl_rd_done = rd_fire;
        bus.cl_wr_done = wr_done_q;
        bus.cl_rd_data = rd_fire ? bus.ram_q : rd_data_q;
        bus.ram_addr   = addr_q;
        bus.ram_data   = data_q;
        bus.ram_wren   = (mem == M_WR);
        busy           = in_run;
        done           = (ph == DONE);
        protocol_err   = perr_q;
        case (ph)
            INIT:    phase = 2'd1;
            KSA:     phase = 2'd2;
            PRGA:    phase = 2'd3;
            default: phase = 2'd0;
        endcase
    end
endmodule

// File: doc/rc4_sequencer.md
RC4_SEQUENCER -- requirements
Module: rc4_sequencer

Interface
REQ-001 SHALL have parameter RD_LAT, default 2, meaning cycles from ram_addr valid to ram_q valid (legal 1..4).
REQ-002 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port nreset  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port go  in  1  one-cycle pulse, starts a full Init->Key Schedule->Decrypt run.
REQ-005 SHALL have port abort  in  1  one-cycle pulse, cancels the run in progress.
REQ-006 SHALL have port cl_start  out  3  one-cycle start pulse per client (bit0 Init, bit1 Key Schedule, bit2 Decrypt).
REQ-007 SHALL have port cl_finish  in  3  one-cycle finish pulse per client.
REQ-008 SHALL have ports cl_rd_start and cl_wr_start  in  3 each  per-client memory request pulses.
REQ-009 SHALL have ports cl_addr and cl_wr_data  in  24 each  per-client byte, client k in bits [8k+7:8k].
REQ-010 SHALL have ports cl_rd_done and cl_wr_done  out  1 each  completion pulses to the active client.
REQ-011 SHALL have port cl_rd_data  out  8  read data, broadcast to all clients.
REQ-012 SHALL have ports ram_addr and ram_data  out  8 each  S-memory address and write data.
REQ-013 SHALL have port ram_wren  out  1  S-memory write enable.
REQ-014 SHALL have port ram_q  in  8  S-memory read data.
REQ-015 SHALL have ports busy, done, protocol_err  out  1 each, and phase  out  2.

Function
REQ-016 Phase FSM SHALL have states IDLE, INIT, KSA, PRGA, DONE; phase = 0/1/2/3 in IDLE/INIT/KSA/PRGA, 0 in DONE.
REQ-017 go sampled in IDLE at cycle N SHALL enter INIT with cl_start[0]=1 at N+1 only; go outside IDLE SHALL be ignored.
REQ-018 cl_finish[k] of active client at cycle M SHALL advance INIT->KSA or KSA->PRGA with cl_start[k+1]=1 at M+1, or PRGA->DONE.
REQ-019 cl_finish from a non-active client SHALL be ignored.
REQ-020 DONE SHALL last one cycle with done=1, then return to IDLE; busy=1 exactly in INIT, KSA, PRGA.
REQ-021 Only the active client's rd_start/wr_start/addr/wr_data SHALL be honoured; inactive clients' requests SHALL be ignored with no flag.
REQ-022 Memory engine SHALL have states M_IDLE, M_RD, M_WR, and SHALL accept requests only in M_IDLE.
REQ-023 Read: rd_start at cycle T SHALL latch addr, drive ram_addr from T+1 with ram_wren=0, and at T+1+RD_LAT load ram_q into cl_rd_data with cl_rd_done=1 for one cycle.
REQ-024 Write: wr_start at T SHALL drive ram_addr/ram_data with ram_wren=1 for cycle T+1 only, and cl_wr_done=1 at T+2 for one cycle.
REQ-025 cl_rd_data SHALL hold its value until the next read completes.
REQ-026 Simultaneous rd_start and wr_start SHALL perform the write, drop the read, and set protocol_err.
REQ-027 A request while the engine is not M_IDLE SHALL be dropped and set protocol_err; protocol_err SHALL be sticky until go or reset.
REQ-028 abort SHALL move both FSMs to IDLE/M_IDLE next cycle, with ram_wren=0 and no done/cl_start/cl_done pulses; abort in IDLE SHALL have no effect.
REQ-029 A phase transition SHALL wait while an access is outstanding; the done pulse SHALL complete first, then the transition occurs.
REQ-030 Addresses SHALL be 8-bit with no arithmetic; all 256 addresses, including 0xFF, SHALL pass unmodified.

Reset
REQ-031 nreset low SHALL asynchronously force IDLE and M_IDLE, all outputs 0, cl_rd_data=0, and protocol_err=0, including mid-access.
REQ-032 After nreset rises, the first go SHALL be accepted on the first clock edge.

Verification
REQ-033 go at cycle 10, finish[0]@20, finish[1]@40, finish[2]@60 -> cl_start 001@11, 010@21, 100@41; done@61; busy high cycles 11..60.
REQ-034 RD_LAT=2, INIT active, rd_start[0]@T with addr 0xFF and ram model returning 0x5A -> ram_addr=0xFF@T+1; cl_rd_done=1 and cl_rd_data=0x5A@T+3.
REQ-035 KSA active, wr_start[1]@T with addr 0x03 and data 0xC7 -> ram_wren=1 and ram_addr=0x03/ram_data=0xC7@T+1 only; cl_wr_done@T+2.
REQ-036 rd_start[1] and wr_start[1] same cycle, then rd_start[1] during M_WR -> one write only; protocol_err=1 until next go.
REQ-037 Stray cl_finish[2] and wr_start[2] during INIT -> no phase change; ram_wren stays 0.
REQ-038 abort, then separately nreset low, each during an M_WR access -> ram_wren=0 next cycle (abort) or immediately (reset); IDLE; no done pulse.
